// File: rtl/seq_u_arrtm.sv
`default_nettype none
// ============================================================================
// Module   : seq_u_arrtm
// Purpose  : Sequential shift-and-add unsigned multiplier with runtime
//            truncation. The operand bits below ke = min(k, N-1) are
//            dropped, giving ((a >> ke) * (b >> ke)) << (2*ke), and one
//            multiplier row is accumulated per cycle. The result is
//            returned over a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module seq_u_arrtm #(
  parameter int N  = 8,
  parameter int KW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N-1:0]    a,
  input  logic [N-1:0]    b,
  input  logic [KW-1:0]   k,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*N-1:0]  prod,
  output logic            busy
);

  // Width of the row index, which runs from ke up to N-1.
  localparam int JW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]     state_q, state_d;
  logic [N-1:0]   a_q, a_d;
  logic [N-1:0]   b_q, b_d;
  logic [2*N-1:0] acc_q, acc_d;
  logic [JW-1:0]  j_q, j_d;
  logic [2*N-1:0] prod_q, prod_d;

  logic [31:0]    k_ext;
  logic [JW-1:0]  ke;
  logic [N-1:0]   keep_mask;
  logic [2*N-1:0] row;
  logic [2*N-1:0] sum;
  logic           last_row;

  // The truncation level saturates at N-1, so at least the top row is
  // always processed.
  assign k_ext     = 32'(k);
  assign ke        = (k_ext > 32'(N - 1)) ? JW'(N - 1) : JW'(k_ext);
  assign keep_mask = {N{1'b1}} << ke;

  // One partial-product row. Because b_q has its low ke bits cleared and
  // the row index starts at ke, only a[i]&b[j] with i,j >= ke contribute.
  assign row      = {{N{1'b0}}, (a_q & {N{b_q[j_q]}})} << j_q;
  assign sum      = acc_q + row;
  assign last_row = (j_q == JW'(N - 1));

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign prod      = prod_q;

  // Next-state logic: accept in IDLE, one row per cycle in MUL, hold in DONE.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    j_d     = j_q;
    prod_d  = prod_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a & keep_mask;
          b_d     = b & keep_mask;
          acc_d   = '0;
          j_d     = ke;
          state_d = MUL;
        end
      end
      MUL: begin
        acc_d = sum;
        j_d   = j_q + 1'b1;
        if (last_row) begin
          prod_d  = sum;
          state_d = DONE;
        end
      end
      DONE: begin
        // No acceptance here: a new operand set waits for IDLE.
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      j_q     <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      j_q     <= j_d;
      prod_q  <= prod_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_u_arrtm.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_u_arrtm
// Purpose  : Self-checking bench for seq_u_arrtm (N=8). A transaction-level
//            model tracks the expected handshake phase and result, and it
//            is compared with the DUT every cycle. Directed cases pin the
//            model with hand-computed products and latencies.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_u_arrtm;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [7:0]   a_s = '0;
  logic [7:0]   b_s = '0;
  logic [2:0]   k_s = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [15:0]  prod;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int hs_count = 0;
  bit armed = 1'b0;

  seq_u_arrtm #(.N(N), .KW(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a_s),
    .b         (b_s),
    .k         (k_s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .prod      (prod),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int eff_k(input logic [2:0] kk);
    return (int'(kk) > N - 1) ? N - 1 : int'(kk);
  endfunction

  // Product definition: truncate both operands, multiply, scale back.
  function automatic logic [15:0] ref_prod(input logic [7:0] aa, input logic [7:0] bb,
                                           input logic [2:0] kk);
    longint x;
    int ke;
    ke = eff_k(kk);
    x  = (longint'(aa) >> ke) * (longint'(bb) >> ke);
    x  = x << (2 * ke);
    return x[15:0];
  endfunction

  // Transaction-level model: 0 = idle, 1 = computing, 2 = result held.
  int          m_phase = 0;
  int          m_cnt   = 0;
  logic [15:0] m_res   = '0;
  logic [15:0] m_prod  = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_phase <= 0;
      m_cnt   <= 0;
      m_prod  <= '0;
    end else begin
      case (m_phase)
        0: if (in_valid) begin
          m_res   <= ref_prod(a_s, b_s, k_s);
          m_cnt   <= N - eff_k(k_s);
          m_phase <= 1;
        end
        1: begin
          if (m_cnt == 1) begin
            m_phase <= 2;
            m_prod  <= m_res;
          end
          m_cnt <= m_cnt - 1;
        end
        default: if (out_ready) m_phase <= 0;
      endcase
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (armed) begin
      check("in_ready",  {63'd0, in_ready},  {63'd0, (m_phase == 0)});
      check("out_valid", {63'd0, out_valid}, {63'd0, (m_phase == 2)});
      check("busy",      {63'd0, busy},      {63'd0, (m_phase != 0)});
      check("prod",      {48'd0, prod},      {48'd0, m_prod});
      if (out_valid && out_ready && !rst) hs_count++;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Launch one operation and wait for its result; leaves it held in DONE.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic [2:0] tk,
                        input logic [15:0] exp_p, input int exp_lat, input string tag);
    int g;
    int lat;
    g = 0;
    while (!in_ready && g < 50) begin
      tick();
      g++;
    end
    check({tag, "_ready_wait"}, {63'd0, (g < 50)}, 64'd1);
    a_s = ta; b_s = tb_v; k_s = tk; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_prod"}, {48'd0, prod}, {48'd0, exp_p});
  endtask

  task automatic finish_op(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_idle_ready"}, {63'd0, in_ready}, 64'd1);
    check({tag, "_idle_ovalid"}, {63'd0, out_valid}, 64'd0);
  endtask

  initial begin
    int stray;
    int target;
    int cyc;

    // Reset state.
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    armed = 1'b1;
    check("rst_in_ready",  {63'd0, in_ready},  64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_busy",      {63'd0, busy},      64'd0);
    check("rst_prod",      {48'd0, prod},      64'd0);

    // Directed products and latencies.
    run_op(8'hFF, 8'hFF, 3'd7, 16'h4000, 1, "k7");
    finish_op("k7");
    run_op(8'hFF, 8'hFF, 3'd0, 16'hFE01, 8, "k0");
    finish_op("k0");
    check("idle_holds_prod", {48'd0, prod}, 64'h0000_0000_0000_FE01);
    run_op(8'h07, 8'hFF, 3'd3, 16'h0000, 5, "k3");
    finish_op("k3");

    // Backpressure: result held, new requests ignored.
    run_op(8'hF3, 8'h2C, 3'd4, 16'h1E00, 4, "k4");
    a_s = 8'h55; b_s = 8'hAA; k_s = 3'd0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_prod",      {48'd0, prod},      64'h1E00);
      check("bp_out_valid", {63'd0, out_valid}, 64'd1);
      check("bp_in_ready",  {63'd0, in_ready},  64'd0);
    end
    in_valid = 1'b0;
    finish_op("bp");
    check("bp_prod_after", {48'd0, prod}, 64'h1E00);

    // Reset in the middle of a multiply.
    run_op(8'hFF, 8'hFF, 3'd0, 16'hFE01, 8, "pre_rst");
    finish_op("pre_rst");
    a_s = 8'hC3; b_s = 8'h5A; k_s = 3'd0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mr_in_ready",  {63'd0, in_ready},  64'd1);
    check("mr_out_valid", {63'd0, out_valid}, 64'd0);
    check("mr_prod",      {48'd0, prod},      64'd0);
    stray = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid) stray++;
    end
    check("mr_no_stray", 64'(stray), 64'd0);

    // Back-to-back random operations with both valids held high.
    target = hs_count + 1000;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    cyc = 0;
    while (hs_count < target && cyc < 20000) begin
      a_s = 8'($urandom);
      b_s = 8'($urandom);
      k_s = 3'($urandom_range(0, 7));
      tick();
      cyc++;
    end
    check("b2b_completed", {63'd0, (hs_count >= target)}, 64'd1);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
